// File: rtl/packer_pkg.sv
// Shared types and sizing helpers for the byte-to-word packer.
// Imported by the packer top level and its word FIFO.
package packer_pkg;

    typedef enum logic {
        LOW,
        HIGH
    } phase_t;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO of 16-bit words with registered storage.
// Head entry is presented combinationally; reads 0 when empty.
module word_fifo
    import packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WORD_W-1:0]         din,
    input  logic                      pop,
    output logic [WORD_W-1:0]         dout,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = nxt(wr_q);
        end
        if (do_pop) begin
            rd_d = nxt(rd_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs consecutive accepted bytes into 16-bit words and buffers
// them in a small FIFO toward a word-wide consumer.
module byte_word_packer
    import packer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    input  logic              out_ready,
    output logic              half
);

    phase_t            phase_q, phase_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              accept;
    logic              push;
    logic [WORD_W-1:0] word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [cnt_w(DEPTH)-1:0] fifo_count;
    logic              unused_count;

    // Fullness is judged on registered state, so a pending pop
    // never lets a second byte slip in during the same cycle.
    assign in_ready = !rst && !flush
                    && ((phase_q == LOW) || !fifo_full);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (phase_q == HIGH);
    assign half     = (phase_q == HIGH);
    assign out_valid = !fifo_empty;
    assign unused_count = ^fifo_count;

    assign word = MSB_FIRST ? {hold_q, in_byte}
                            : {in_byte, hold_q};

    always_comb begin
        phase_d = phase_q;
        hold_d  = hold_q;
        if (flush) begin
            phase_d = LOW;
        end else if (accept) begin
            unique case (phase_q)
                LOW: begin
                    hold_d  = in_byte;
                    phase_d = HIGH;
                end
                HIGH: begin
                    phase_d = LOW;
                end
                default: phase_d = LOW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= LOW;
            hold_q  <= '0;
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
        end
    end

    word_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (word),
        .pop   (out_ready),
        .dout  (out_word),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
